// File: rtl/fft_bitrev_reorder_pkg.sv
// Shared FFT definitions: default frame size and sample width, read FSM state type,
// and the bit-reversal helper also used by the FFT/IFFT ordering logic.
package fft_bitrev_reorder_pkg;

  localparam int unsigned DefTotalStep = 5;
  localparam int unsigned DefDataWidth = 16;

  typedef enum logic {
    StIdle,
    StRead
  } rd_state_e;

  // Reverse the low 'width' bits of 'value'; bits above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) begin
        res = {res[30:0], value[i]};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM for the reorder ping-pong buffer.
// Ports:
//   clk_i    - clock, rising edge
//   we_i     - write enable
//   waddr_i  - write address (MSB selects bank)
//   wdata_i  - write data
//   re_i     - read enable; read data is registered
//   raddr_i  - read address (MSB selects bank)
//   rdata_o  - registered read data, holds when re_i=0
module fft_reorder_ram
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned AddrWidth = DefTotalStep + 1,
  parameter int unsigned DataWidth = 2 * DefDataWidth
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 1 << AddrWidth;

  logic [DataWidth-1:0] mem [Depth];

  // Contents are never reset; the full flags decide what is valid.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Converts an FFT output stream from bit-reversed order into natural order using a
// two-bank ping-pong buffer. Writes scatter to bit-reversed addresses, reads sweep linearly.
// Ports:
//   iclk         - clock, rising edge
//   rst          - synchronous active-high reset
//   ien          - input sample valid (bit-reversed stream order)
//   iReal/iImag  - signed complex input sample
//   oen          - output sample valid (natural order)
//   oReal/oImag  - complex output sample, zero when oen=0
//   ostart/olast - first / last sample of an output frame
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter int unsigned TOTAL_STEP = DefTotalStep,
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                         iclk,
  input  logic                         rst,
  input  logic                         ien,
  input  logic signed [DATA_WIDTH-1:0] iReal,
  input  logic signed [DATA_WIDTH-1:0] iImag,
  output logic                         oen,
  output logic signed [DATA_WIDTH-1:0] oReal,
  output logic signed [DATA_WIDTH-1:0] oImag,
  output logic                         ostart,
  output logic                         olast
);

  localparam logic [TOTAL_STEP-1:0] CntMax = '1;

  logic [TOTAL_STEP-1:0] wcnt_q;
  logic                  wbank_q;
  logic [1:0]            full_q;
  rd_state_e             state_q;
  logic [TOTAL_STEP-1:0] rcnt_q;
  logic                  rbank_q;
  logic                  oen_q, ostart_q, olast_q;

  logic                    wrap;
  logic                    read_end;
  logic [1:0]              full_set, full_clr;
  logic                    other_full;
  logic                    oldest_bank;
  logic [31:0]             wrev;
  logic [TOTAL_STEP:0]     waddr, raddr;
  logic [2*DATA_WIDTH-1:0] rdata;
  logic                    unused_wrev;

  // ---------------------------------------------------------------- write side
  assign wrap        = ien && (wcnt_q == CntMax);
  assign wrev        = bitrev(32'(wcnt_q), TOTAL_STEP);
  assign waddr       = {wbank_q, wrev[TOTAL_STEP-1:0]};
  assign unused_wrev = ^wrev[31:TOTAL_STEP];

  always_ff @(posedge iclk) begin
    if (rst) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
    end else if (ien) begin
      wcnt_q <= wcnt_q + 1'b1;
      if (wrap) begin
        wbank_q <= ~wbank_q;
      end
    end
  end

  // ---------------------------------------------------------------- bank flags
  assign read_end    = (state_q == StRead) && (rcnt_q == CntMax);
  assign full_set    = {wrap & wbank_q, wrap & ~wbank_q};
  assign full_clr    = {read_end & rbank_q, read_end & ~rbank_q};
  // A bank completing on the same edge the current read ends still chains on.
  assign other_full  = full_q[~rbank_q] | full_set[~rbank_q];
  // With both banks full the write pointer has lapped back onto the older one.
  assign oldest_bank = (full_q == 2'b11) ? wbank_q : full_q[1];

  always_ff @(posedge iclk) begin
    if (rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= (full_q & ~full_clr) | full_set;
    end
  end

  // ---------------------------------------------------------------- read FSM
  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q  <= StIdle;
      rcnt_q   <= '0;
      rbank_q  <= 1'b0;
      oen_q    <= 1'b0;
      ostart_q <= 1'b0;
      olast_q  <= 1'b0;
    end else begin
      // Flags track the RAM read issued this cycle, which lands next cycle.
      oen_q    <= (state_q == StRead);
      ostart_q <= (state_q == StRead) && (rcnt_q == '0);
      olast_q  <= read_end;
      unique case (state_q)
        StIdle: begin
          if (|full_q) begin
            state_q <= StRead;
            rcnt_q  <= '0;
            rbank_q <= oldest_bank;
          end
        end
        StRead: begin
          rcnt_q <= rcnt_q + 1'b1;
          if (read_end) begin
            if (other_full) begin
              rbank_q <= ~rbank_q;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign raddr = {rbank_q, rcnt_q};

  fft_reorder_ram #(
    .AddrWidth(TOTAL_STEP + 1),
    .DataWidth(2 * DATA_WIDTH)
  ) u_ram (
    .clk_i  (iclk),
    .we_i   (ien & ~rst),
    .waddr_i(waddr),
    .wdata_i({iReal, iImag}),
    .re_i   (state_q == StRead),
    .raddr_i(raddr),
    .rdata_o(rdata)
  );

  // ---------------------------------------------------------------- outputs
  assign oen    = oen_q;
  assign ostart = ostart_q;
  assign olast  = olast_q;
  assign oReal  = oen_q ? rdata[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign oImag  = oen_q ? rdata[DATA_WIDTH-1:0] : '0;

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 The module SHALL have parameter TOTAL_STEP, default 5, giving log2 of the frame length N = 2^TOTAL_STEP.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 16, giving the width of each real and imaginary sample.
REQ-003 The module SHALL have port iclk, input, 1 bit: the single clock; all logic is clocked on the rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port ien, input, 1 bit: input sample valid, a stream in FFT bit-reversed output order.
REQ-006 The module SHALL have port iReal, input, DATA_WIDTH bits: signed real part, sampled when ien=1.
REQ-007 The module SHALL have port iImag, input, DATA_WIDTH bits: signed imaginary part, sampled when ien=1.
REQ-008 The module SHALL have port oen, output, 1 bit: output sample valid, in natural order.
REQ-009 The module SHALL have port oReal, output, DATA_WIDTH bits: real part of the output.
REQ-010 The module SHALL have port oImag, output, DATA_WIDTH bits: imaginary part of the output.
REQ-011 The module SHALL have port ostart, output, 1 bit: high with the first oen cycle of each frame (index 0).
REQ-012 The module SHALL have port olast, output, 1 bit: high with the last oen cycle of each frame (index N-1).
REQ-013 The module SHALL NOT have a backpressure input; the consumer always accepts.

Function
REQ-014 The module SHALL use a ping-pong buffer of two banks, each holding N complex entries.
REQ-015 The module SHALL keep a write counter wcnt (TOTAL_STEP bits) and a write bank select wbank.
REQ-016 On each ien=1 edge, the module SHALL store {iReal,iImag} at address bitrev(wcnt) of bank wbank, then increment wcnt; ien=0 leaves wcnt unchanged, so input gaps are permitted.
REQ-017 When wcnt wraps from N-1 to 0, the module SHALL mark bank wbank full and toggle wbank on the same edge.
REQ-018 The read FSM SHALL have two states: IDLE and READ; it moves IDLE->READ when any bank is full, starting at rcnt=0 on the oldest full bank.
REQ-019 In READ, the module SHALL advance rcnt by 1 every cycle, without gaps; at rcnt=N-1 it clears that bank's full flag.
REQ-020 At rcnt=N-1, the FSM SHALL continue in READ at rcnt=0 on the other bank if that bank is full (including when it becomes full on that same edge), and SHALL otherwise return to IDLE.
REQ-021 Output k of a frame SHALL equal the input sample written at stream position bitrev(k).
REQ-022 Latency: the first oen SHALL be asserted exactly 2 edges after the edge that samples a frame's last ien (1 edge for the bank/FSM update, 1 edge for the registered RAM read).
REQ-023 When oen=0, oReal, oImag, ostart and olast SHALL be driven to 0.
REQ-024 Data SHALL pass through bit-exact, with no scaling or sign change.
REQ-025 With continuous input at 1 sample per cycle, no overflow SHALL occur; read drains a bank in N cycles, which is no longer than the next fill takes.

Reset
REQ-026 While rst=1, the module SHALL hold wcnt=0, wbank=0, rcnt=0, both full flags=0, the FSM in IDLE, and oen, ostart, olast, oReal, oImag=0.
REQ-027 Reset asserted mid-frame or mid-burst SHALL discard all buffered data; on the edge after rst falls, oen=0 and the next ien begins frame index 0.
REQ-028 RAM contents SHALL NOT require reset.

Structure
REQ-029 The shared FFT package/include SHALL hold the TOTAL_STEP and DATA_WIDTH defaults and a bitrev(value, width) function, which is reused by FFT_IFFT ordering logic.
REQ-030 The module SHALL instantiate one sub-module, fft_reorder_ram: a simple dual-port RAM of 2N x 2*DATA_WIDTH, 1 write port, 1 read port, registered read; its address MSB is the bank select.

Verification (N=32 unless stated)
REQ-031 Single frame: 32 contiguous ien with iReal=k, iImag=-k at stream position k -> 32 contiguous oen; out[1]=(16,-16), out[3]=(24,-24), out[31]=(31,-31); ostart on out[0], olast on out[31].
REQ-032 Three back-to-back frames: 96 contiguous ien -> 96 contiguous oen with no gap; ostart/olast at cycles 0/31, 32/63 and 64/95 of the burst.
REQ-033 Gapped input: ien on alternate cycles -> same values as REQ-031; the output burst is contiguous and starts 2 edges after the 32nd accepted sample.
REQ-034 Reset after 10 samples, then a full frame -> exactly 32 oen cycles, matching REQ-031 values; no residue from the first 10 samples.
REQ-035 Reset pulse at out[5] of a burst -> oen=0 from the next edge; all outputs 0; no further oen until a new full frame arrives.
REQ-036 TOTAL_STEP=3, input k=0..7 -> output order 0,4,2,6,1,5,3,7.
